// File: rtl/cdu_adc_sequencer.sv
// ============================================================================
// cdu_adc_sequencer
// ----------------------------------------------------------------------------
// Steps a small programmable table of ADC1..ADC12 mode words out to NCH
// coupling-data-unit channels (gimbal axes). Each program entry holds a
// 12-bit mode word, a per-channel enable mask, a dwell length in tick strobes
// and a "last" flag. Between two steps the outputs are forced to zero for one
// clock so that no channel ever sees two mode words overlap.
//
// Timing: the FSM state register follows the inputs on the edge that samples
// them; the output registers are derived from that state on the following
// edge, so a start sampled at edge n shows step 0 on adc/busy after edge n+1.
// abort and rst act on the output registers directly, so they zero the
// outputs on the very edge that samples them.
//
// Optional feature: define CDU_SEQ_LOOP_EN to add the `loop` input. With
// loop=1, a terminating step returns to step 0 (through the one-clock gap)
// instead of finishing with a done pulse.
//
// Parameters
//   NCH      number of CDU channels driven
//   NSTEP    program depth in steps (power of two, 2..64)
//   DWELL_W  dwell counter width in ticks
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset (also clears the program table)
//   loop        (CDU_SEQ_LOOP_EN only) restart at step 0 instead of finishing
//   tick        one-clk dwell timebase strobe
//   start       begin the program at step 0 (ignored while busy)
//   abort       return to idle at once, outputs to zero, no done pulse
//   prog_we     program-entry write strobe (accepted only while idle)
//   prog_addr   entry being written
//   prog_mode   ADC1..ADC12 mode word, bit0 = ADC1
//   prog_mask   channels that receive this entry's mode word
//   prog_dwell  entry length in ticks (0 behaves as 1)
//   prog_last   entry terminates the program
//   adc         per-channel mode lines, channel c at [12c+11:12c]
//   busy        sequencer is running a program
//   step        active step (RUN), next step (GAP), 0 when idle
//   done        one-clock completion pulse
//   prog_err    one-clock pulse for a write attempted while busy
// ============================================================================
module cdu_adc_sequencer #(
    parameter  int NCH     = 3,
    parameter  int NSTEP   = 8,
    parameter  int DWELL_W = 24,
    localparam int AW      = $clog2(NSTEP)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CDU_SEQ_LOOP_EN
    input  logic                 loop,
`endif
    input  logic                 tick,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [11:0]          prog_mode,
    input  logic [NCH-1:0]       prog_mask,
    input  logic [DWELL_W-1:0]   prog_dwell,
    input  logic                 prog_last,
    output logic [12*NCH-1:0]    adc,
    output logic                 busy,
    output logic [AW-1:0]        step,
    output logic                 done,
    output logic                 prog_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Program table
    // ------------------------------------------------------------------
    logic [11:0]        mode_mem  [NSTEP];
    logic [NCH-1:0]     mask_mem  [NSTEP];
    logic [DWELL_W-1:0] dwell_mem [NSTEP];
    logic               last_mem  [NSTEP];

    // ------------------------------------------------------------------
    // Sequencer state and output registers
    // ------------------------------------------------------------------
    state_t             state_q;
    logic [AW-1:0]      step_q;      // step being run, or next step in GAP
    logic [DWELL_W-1:0] cnt_q;       // ticks remaining in the active step
    logic [12*NCH-1:0]  adc_q;
    logic               busy_q;
    logic [AW-1:0]      step_out_q;
    logic               done_q;
    logic               prog_err_q;

    // Next values of the output registers, derived from the current state.
    logic [12*NCH-1:0]  adc_d;
    logic               busy_d;
    logic [AW-1:0]      step_out_d;
    logic               done_d;

    // Helpers for the FSM.
    logic [DWELL_W-1:0] start_dwell;
    logic [DWELL_W-1:0] next_dwell;
    logic               step_terminal;
    logic               loop_en;
    logic [AW-1:0]      step_inc;

    // A programmed dwell of zero still has to last one tick.
    function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

`ifdef CDU_SEQ_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign start_dwell   = eff_dwell(dwell_mem[0]);
    assign next_dwell    = eff_dwell(dwell_mem[step_q]);
    assign step_terminal = last_mem[step_q] || (step_q == AW'(NSTEP - 1));
    assign step_inc      = step_q + AW'(1);

    // NOTE: every signal driven here gets a default before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        adc_d      = '0;
        busy_d     = (state_q != S_IDLE);
        step_out_d = (state_q == S_IDLE) ? '0 : step_q;
        done_d     = (state_q == S_DONE);
        if (state_q == S_RUN) begin
            for (int c = 0; c < NCH; c++) begin
                adc_d[12*c +: 12] = mask_mem[step_q][c] ? mode_mem[step_q] : 12'h000;
            end
        end
    end

    // ------------------------------------------------------------------
    // Program table writes. Only accepted while idle so a running program
    // never changes underneath the sequencer.
    // ------------------------------------------------------------------
    // NOTE: the table is reset explicitly because a cleared program is part
    // of the block's defined behaviour; this keeps it in flops rather than a
    // RAM macro, which is fine at this depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSTEP; i++) begin
                mode_mem[i]  <= '0;
                mask_mem[i]  <= '0;
                dwell_mem[i] <= '0;
                last_mem[i]  <= 1'b0;
            end
        end else if (prog_we && (state_q == S_IDLE)) begin
            mode_mem[prog_addr]  <= prog_mode;
            mask_mem[prog_addr]  <= prog_mask;
            dwell_mem[prog_addr] <= prog_dwell;
            last_mem[prog_addr]  <= prog_last;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // in this block sees the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            cnt_q      <= '0;
            adc_q      <= '0;
            busy_q     <= 1'b0;
            step_out_q <= '0;
            done_q     <= 1'b0;
            prog_err_q <= 1'b0;
        end else begin
            prog_err_q <= prog_we && (state_q != S_IDLE);

            if (abort) begin
                // Abort wins over start and suppresses any pending done pulse.
                state_q    <= S_IDLE;
                step_q     <= '0;
                cnt_q      <= '0;
                adc_q      <= '0;
                busy_q     <= 1'b0;
                step_out_q <= '0;
                done_q     <= 1'b0;
            end else begin
                adc_q      <= adc_d;
                busy_q     <= busy_d;
                step_out_q <= step_out_d;
                done_q     <= done_d;

                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q <= S_RUN;
                            step_q  <= '0;
                            cnt_q   <= start_dwell;
                        end
                    end

                    S_RUN: begin
                        // Only tick strobes consume dwell.
                        if (tick) begin
                            if (cnt_q <= DWELL_W'(1)) begin
                                cnt_q <= '0;
                                if (step_terminal) begin
                                    if (loop_en) begin
                                        state_q <= S_GAP;
                                        step_q  <= '0;
                                    end else begin
                                        state_q <= S_DONE;
                                    end
                                end else begin
                                    state_q <= S_GAP;
                                    step_q  <= step_inc;
                                end
                            end else begin
                                cnt_q <= cnt_q - DWELL_W'(1);
                            end
                        end
                    end

                    S_GAP: begin
                        // One dead clock between steps; ticks are not counted.
                        state_q <= S_RUN;
                        cnt_q   <= next_dwell;
                    end

                    S_DONE: begin
                        state_q <= S_IDLE;
                        step_q  <= '0;
                    end

                    default: begin
                        state_q <= S_IDLE;
                        step_q  <= '0;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign adc      = adc_q;
    assign busy     = busy_q;
    assign step     = step_out_q;
    assign done     = done_q;
    assign prog_err = prog_err_q;

endmodule
